// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Busy-bit scoreboard hazard unit for the 5-stage pipelined MIPS core. It sits
// beside the control unit between decode and execute. Pending register writes
// come from two sources:
//   - loads, which travel through a LOAD_LAT-deep shadow pipe;
//   - a multi-cycle multiply/divide unit tracked by an IDLE/BUSY/DONE FSM.
// From this state it produces the decode stall, the execute bubble and the
// decode flush.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   issue_vld       decode holds a valid instruction trying to advance
//   rs_d, rt_d      decode source registers, qualified by uses_rs / uses_rt
//   dst_d, wr_d     decode destination register and its write enable
//   is_load_d       decode instruction is a load
//   is_md_d         decode instruction is a multiply/divide
//   branch_taken    branch resolved taken in decode
//   stall_f         hold PC
//   stall_d         hold decode register
//   flush_e         insert bubble into execute
//   flush_d         clear decode register
//   md_busy         md FSM not IDLE
//   md_done         md result completes this cycle
//
// Optional feature (macro HAZ_PERF_CNT_EN): adds the saturating 32-bit
// counters stall_cnt and flush_cnt, which count stall_d and flush_d cycles.

`timescale 1ns/1ps

module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_vld,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic          uses_rs,
  input  logic          uses_rt,
  input  logic [AW-1:0] dst_d,
  input  logic          wr_d,
  input  logic          is_load_d,
  input  logic          is_md_d,
  input  logic          branch_taken,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_e,
  output logic          flush_d,
  output logic          md_busy,
  output logic          md_done
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  localparam int CW = $clog2(MD_LAT);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t           state, next_state;
  logic [NREG-1:0]     busy, busy_next;
  logic [LOAD_LAT-1:0] pipe_vld;
  logic [AW-1:0]       pipe_dst [LOAD_LAT];
  logic [CW-1:0]       md_cnt;
  logic [AW-1:0]       md_dst;
  logic                md_wr;

  logic rs_hz, rt_hz, waw, md_struct, hazard, accept, load_push, md_start;

  // Hazard detection and the resulting pipeline controls. Every output is
  // held low while reset is asserted, regardless of the stored state.
  always_comb begin
    rs_hz     = uses_rs & (rs_d != '0) & busy[rs_d];
    rt_hz     = uses_rt & (rt_d != '0) & busy[rt_d];
    waw       = wr_d & (dst_d != '0) & busy[dst_d];
    md_struct = is_md_d & (state != MD_IDLE);
    hazard    = issue_vld & (rs_hz | rt_hz | waw | md_struct);
    accept    = issue_vld & ~hazard;
    load_push = accept & is_load_d & wr_d & (dst_d != '0);
    md_start  = accept & is_md_d & (state == MD_IDLE);

    stall_d = hazard & ~rst;
    stall_f = hazard & ~rst;
    flush_e = hazard & ~rst;
    // A taken branch seen during a stall is dropped; decode re-resolves it
    // once the stall lifts.
    flush_d = branch_taken & ~hazard & ~rst;
    md_busy = (state != MD_IDLE) & ~rst;
    md_done = (state == MD_DONE) & ~rst;
  end

  // Multiply/divide FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      MD_IDLE: if (md_start) next_state = MD_BUSY;
      MD_BUSY: if (md_cnt == '0) next_state = MD_DONE;
      MD_DONE: next_state = MD_IDLE;
      default: next_state = MD_IDLE;
    endcase
  end

  // FSM state register plus the countdown and the latched md destination.
  // The destination write flag is stored already qualified by dst != 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
      md_dst <= '0;
      md_wr  <= 1'b0;
    end else begin
      state <= next_state;
      if (md_start) begin
        md_cnt <= CW'(MD_LAT - 1);
        md_dst <= dst_d;
        md_wr  <= wr_d & (dst_d != '0);
      end else if (state == MD_BUSY && md_cnt != '0) begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

  // Busy-bit update. Clears are applied first and sets last, so a set and a
  // clear of the same register in one cycle leave it busy. A load-pipe clear
  // and an md clear to different registers both take effect.
  always_comb begin
    busy_next = busy;
    if (pipe_vld[LOAD_LAT-1]) busy_next[pipe_dst[LOAD_LAT-1]] = 1'b0;
    if (state == MD_DONE && md_wr) busy_next[md_dst] = 1'b0;
    if (load_push) busy_next[dst_d] = 1'b1;
    if (md_start && wr_d && dst_d != '0) busy_next[dst_d] = 1'b1;
  end

  // Scoreboard and load shadow pipe. An entry clears its busy bit on the edge
  // where it leaves the last stage, so a consumer that arrives right behind
  // the load waits exactly LOAD_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pipe_vld <= '0;
      for (int i = 0; i < LOAD_LAT; i++) pipe_dst[i] <= '0;
    end else begin
      busy        <= busy_next;
      pipe_vld[0] <= load_push;
      pipe_dst[0] <= dst_d;
      for (int i = 1; i < LOAD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dst[i] <= pipe_dst[i-1];
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating performance counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush_d && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. Two instances share the same input
// drive: dut1 uses LOAD_LAT=1 and dut3 uses LOAD_LAT=3. Each scenario checks
// only the instance it targets. The control outputs are compared as the packed
// vector {stall_f, stall_d, flush_e, flush_d, md_busy, md_done}.

`timescale 1ns/1ps

module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_vld, uses_rs, uses_rt, wr_d, is_load_d, is_md_d, branch_taken;
  logic [4:0] rs_d, rt_d, dst_d;

  logic stall_f1, stall_d1, flush_e1, flush_d1, md_busy1, md_done1;
  logic stall_f3, stall_d3, flush_e3, flush_d3, md_busy3, md_done3;
  logic [5:0] o1, o3;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign o1 = {stall_f1, stall_d1, flush_e1, flush_d1, md_busy1, md_done1};
  assign o3 = {stall_f3, stall_d3, flush_e3, flush_d3, md_busy3, md_done3};

  hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(1), .MD_LAT(4)) dut1 (
    .clk(clk), .rst(rst), .issue_vld(issue_vld), .rs_d(rs_d), .rt_d(rt_d),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .dst_d(dst_d), .wr_d(wr_d),
    .is_load_d(is_load_d), .is_md_d(is_md_d), .branch_taken(branch_taken),
    .stall_f(stall_f1), .stall_d(stall_d1), .flush_e(flush_e1),
    .flush_d(flush_d1), .md_busy(md_busy1), .md_done(md_done1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
  );

  hazard_scoreboard #(.NREG(32), .AW(5), .LOAD_LAT(3), .MD_LAT(4)) dut3 (
    .clk(clk), .rst(rst), .issue_vld(issue_vld), .rs_d(rs_d), .rt_d(rt_d),
    .uses_rs(uses_rs), .uses_rt(uses_rt), .dst_d(dst_d), .wr_d(wr_d),
    .is_load_d(is_load_d), .is_md_d(is_md_d), .branch_taken(branch_taken),
    .stall_f(stall_f3), .stall_d(stall_d3), .flush_e(flush_e3),
    .flush_d(flush_d3), .md_busy(md_busy3), .md_done(md_done3)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a decode-stage instruction (or idle when vld=0).
  task automatic set_in(input logic vld, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] dst, input logic wr,
                        input logic ld, input logic md, input logic br);
    issue_vld    = vld;
    rs_d         = rs;
    uses_rs      = urs;
    rt_d         = rt;
    uses_rt      = urt;
    dst_d        = dst;
    wr_d         = wr;
    is_load_d    = ld;
    is_md_d      = md;
    branch_taken = br;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_forced got=%b exp=%b", o1, 6'b000000);
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_idle got=%b exp=%b", o1, 6'b000000);
    end
  endtask

  // LOAD_LAT=1: a dependent instruction stalls exactly one cycle.
  task automatic test_load_use();
    do_reset();
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL load_accept got=%b exp=%b", o1, 6'b000000);
    end
    tick();
    set_in(1, 3, 1, 0, 0, 9, 1, 0, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL load_use_stall got=%b exp=%b", o1, 6'b111000);
    end
    tick();
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL load_use_release got=%b exp=%b", o1, 6'b000000);
    end
    tick();
  endtask

  // LOAD_LAT=3: dependent rt=7 stalls three cycles; independent rs=8 does not.
  task automatic test_load_lat3();
    do_reset();
    set_in(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    set_in(1, 0, 0, 7, 1, 10, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if (o3 !== ((i <= 3) ? 6'b111000 : 6'b000000)) begin
        errors++;
        $display("[TB] FAIL lat3_cycle%0d got=%b exp=%b", i, o3,
                 (i <= 3) ? 6'b111000 : 6'b000000);
      end
      tick();
    end
    do_reset();
    set_in(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    tick();
    set_in(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (o3 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL lat3_independent got=%b exp=%b", o3, 6'b000000);
    end
    tick();
  endtask

  // md dst=5: four BUSY cycles, one DONE cycle. A consumer, a second md op and
  // a WAW writer are each held until the cycle after md_done.
  task automatic test_md();
    for (int scen = 0; scen < 3; scen++) begin
      do_reset();
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
      #1;
      checks++;
      if (o1 !== 6'b000000) begin
        errors++;
        $display("[TB] FAIL md_issue s%0d got=%b exp=%b", scen, o1, 6'b000000);
      end
      tick();
      if (scen == 0) set_in(1, 5, 1, 0, 0, 9, 1, 0, 0, 0);
      else if (scen == 1) set_in(1, 1, 1, 2, 1, 6, 1, 0, 1, 0);
      else set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      for (int c = 1; c <= 6; c++) begin
        #1;
        checks++;
        if (o1 !== ((c <= 4) ? 6'b111010 : (c == 5) ? 6'b111011 : 6'b000000)) begin
          errors++;
          $display("[TB] FAIL md_s%0d_cycle%0d got=%b exp=%b", scen, c, o1,
                   (c <= 4) ? 6'b111010 : (c == 5) ? 6'b111011 : 6'b000000);
        end
        tick();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (o1 !== ((scen == 1) ? 6'b000010 : 6'b000000)) begin
        errors++;
        $display("[TB] FAIL md_s%0d_after got=%b exp=%b", scen, o1,
                 (scen == 1) ? 6'b000010 : 6'b000000);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (o1 !== 6'b000100) begin
      errors++;
      $display("[TB] FAIL branch_flush got=%b exp=%b", o1, 6'b000100);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL branch_clear got=%b exp=%b", o1, 6'b000000);
    end
    tick();
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (o1 !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL branch_in_stall got=%b exp=%b", o1, 6'b111000);
    end
    tick();
    #1;
    checks++;
    if (o1 !== 6'b000100) begin
      errors++;
      $display("[TB] FAIL branch_after_stall got=%b exp=%b", o1, 6'b000100);
    end
    tick();
  endtask

  // Register 0 and non-writing loads never mark anything busy.
  task automatic test_zero_reg();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    set_in(1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL zero_reg got=%b exp=%b", o1, 6'b000000);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 4, 0, 1, 0, 0);
    tick();
    set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL no_wr_load got=%b exp=%b", o1, 6'b000000);
    end
    tick();
  endtask

  // Reset in the middle of an md operation discards it completely.
  task automatic test_reset_mid_md();
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
    tick();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (o1 !== 6'b111010) begin
      errors++;
      $display("[TB] FAIL mid_md_stall got=%b exp=%b", o1, 6'b111010);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL mid_md_rst got=%b exp=%b", o1, 6'b000000);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (o1 !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL mid_md_after got=%b exp=%b", o1, 6'b000000);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (stall_cnt1 !== 32'd0 || flush_cnt1 !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_rst got=%0d/%0d exp=0/0", stall_cnt1, flush_cnt1);
    end
`endif
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (o1 !== 6'b000000) begin
        errors++;
        $display("[TB] FAIL mid_md_quiet%0d got=%b exp=%b", c, o1, 6'b000000);
      end
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    tick();
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (stall_cnt1 !== 32'd1 || flush_cnt1 !== 32'd1) begin
      errors++;
      $display("[TB] FAIL perf_count got=%0d/%0d exp=1/1", stall_cnt1, flush_cnt1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_load_lat3();
    test_md();
    test_branch();
    test_zero_reg();
    test_reset_mid_md();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
